// File: rtl/spi_rx.sv
// SPI mode-0 slave byte receiver: synchronises sclk/ss_n/mosi into the system clock domain,
// emits received bytes with a one-cycle valid strobe and shifts a status byte back on miso.
module spi_rx #(
    parameter int unsigned BitWidth   = 8,
    parameter int unsigned SyncStages = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                sclk_i,
    input  logic                ss_n_i,
    input  logic                mosi_i,
    output logic                miso_o,
    input  logic [BitWidth-1:0] txdata_i,
    output logic [BitWidth-1:0] data_o,
    output logic                valid_o,
    output logic                start_o
);

    localparam int unsigned CntW = (BitWidth > 2) ? $clog2(BitWidth) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(BitWidth - 1);

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    state_e state_q, state_d;

    logic [SyncStages-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q, fresh_q;
    logic                  sclk_dly_q, ss_dly_q;
    logic                  sclk_s, ss_s, mosi_s;
    logic                  sclk_rise, sclk_fall, ss_rise, ss_fall;

    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [BitWidth-1:0] shift_in_q, shift_in_d;
    logic [BitWidth-1:0] shift_out_q, shift_out_d;
    logic [BitWidth-1:0] data_q, data_d;
    logic                skip_q, skip_d;
    logic                valid_q, valid_d;
    logic                start_q, start_d;
    logic                armed_q, armed_d;

    // Pin synchronisers; fresh_q marks when ss_s reflects a genuine post-reset pin sample.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            fresh_q     <= '0;
            sclk_dly_q  <= 1'b0;
            ss_dly_q    <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SyncStages-2:0], sclk_i};
            ss_sync_q   <= {ss_sync_q[SyncStages-2:0], ss_n_i};
            mosi_sync_q <= {mosi_sync_q[SyncStages-2:0], mosi_i};
            fresh_q     <= {fresh_q[SyncStages-2:0], 1'b1};
            sclk_dly_q  <= sclk_s;
            ss_dly_q    <= ss_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SyncStages-1];
    assign ss_s      = ss_sync_q[SyncStages-1];
    assign mosi_s    = mosi_sync_q[SyncStages-1];
    assign sclk_rise = sclk_s & ~sclk_dly_q;
    assign sclk_fall = ~sclk_s & sclk_dly_q;
    assign ss_rise   = ss_s & ~ss_dly_q;
    assign ss_fall   = ~ss_s & ss_dly_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // A frame only starts once ss_n has been seen high after reset (armed_q).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (ss_fall && armed_q) state_d = StActive;
            StActive: if (ss_rise) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        shift_in_d  = shift_in_q;
        shift_out_d = shift_out_q;
        data_d      = data_q;
        skip_d      = skip_q;
        valid_d     = 1'b0;
        start_d     = 1'b0;
        armed_d     = armed_q | (fresh_q[SyncStages-1] & ss_s);
        unique case (state_q)
            StIdle: begin
                if (ss_fall && armed_q) begin
                    start_d     = 1'b1;
                    cnt_d       = '0;
                    shift_out_d = txdata_i;
                    skip_d      = 1'b0;
                end
            end
            StActive: begin
                if (ss_rise) begin
                    cnt_d  = '0;
                    skip_d = 1'b0;
                end else if (sclk_rise) begin
                    shift_in_d = {shift_in_q[BitWidth-2:0], mosi_s};
                    if (cnt_q == CntMax) begin
                        cnt_d       = '0;
                        data_d      = shift_in_d;
                        valid_d     = 1'b1;
                        shift_out_d = txdata_i;
                        skip_d      = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (sclk_fall) begin
                    // Hold the freshly reloaded MSB for the next byte's first rise.
                    if (skip_q) begin
                        skip_d = 1'b0;
                    end else begin
                        shift_out_d = {shift_out_q[BitWidth-2:0], 1'b0};
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            shift_in_q  <= '0;
            shift_out_q <= '0;
            data_q      <= '0;
            skip_q      <= 1'b0;
            valid_q     <= 1'b0;
            start_q     <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            shift_in_q  <= shift_in_d;
            shift_out_q <= shift_out_d;
            data_q      <= data_d;
            skip_q      <= skip_d;
            valid_q     <= valid_d;
            start_q     <= start_d;
            armed_q     <= armed_d;
        end
    end

    assign miso_o  = (state_q == StActive) & shift_out_q[BitWidth-1];
    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign start_o = start_q;

endmodule

// File: tb/tb_spi_rx.sv
// Directed bench for spi_rx: host drives sclk at clk/8 and checks received bytes, strobes and miso.
module tb_spi_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk;
    logic       ss_n;
    logic       mosi;
    logic       miso;
    logic [7:0] txdata;
    logic [7:0] data;
    logic       valid;
    logic       start;

    int         checks = 0;
    int         errors = 0;
    int         start_cnt = 0;
    int         valid_cnt = 0;
    logic [7:0] rx_mem [0:31];
    logic [7:0] mcap;
    logic [7:0] mcap_arr [0:3];

    always #5 clk = ~clk;

    spi_rx #(
        .BitWidth  (8),
        .SyncStages(2)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .sclk_i  (sclk),
        .ss_n_i  (ss_n),
        .mosi_i  (mosi),
        .miso_o  (miso),
        .txdata_i(txdata),
        .data_o  (data),
        .valid_o (valid),
        .start_o (start)
    );

    always @(negedge clk) begin
        if (valid) begin
            if (valid_cnt < 32) rx_mem[valid_cnt] <= data;
            valid_cnt <= valid_cnt + 1;
        end
        if (start) start_cnt <= start_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Clocks nbits of tx MSB first; miso is captured just before each rising edge.
    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = tx[i];
            repeat (4) @(negedge clk);
            rx[i] = miso;
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic frame_end();
        repeat (4) @(negedge clk);
        ss_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        rst    = 1'b1;
        sclk   = 1'b0;
        ss_n   = 1'b1;
        mosi   = 1'b0;
        txdata = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("idle_valid", 32'(valid), 32'h0);
        chk("idle_start", 32'(start), 32'h0);
        chk("idle_miso", 32'(miso), 32'h0);
        chk("idle_data", 32'(data), 32'h0);
        chk("idle_valid_cnt", valid_cnt, 0);
        chk("idle_start_cnt", start_cnt, 0);

        // Single byte 0xA5 while returning status 0x3C.
        txdata = 8'h3C;
        ss_n   = 1'b0;
        xfer(8'hA5, 8, mcap);
        frame_end();
        chk("a5_start_cnt", start_cnt, 1);
        chk("a5_valid_cnt", valid_cnt, 1);
        chk("a5_data", 32'(rx_mem[0]), 32'hA5);
        chk("a5_miso", 32'(mcap), 32'h3C);
        chk("a5_data_held", 32'(data), 32'hA5);
        chk("a5_miso_deselect", 32'(miso), 32'h0);

        // Four back-to-back bytes in one frame; status reloads at each byte start.
        txdata = 8'h96;
        ss_n   = 1'b0;
        xfer(8'h01, 8, mcap_arr[0]);
        xfer(8'h80, 8, mcap_arr[1]);
        xfer(8'hFF, 8, mcap_arr[2]);
        xfer(8'h00, 8, mcap_arr[3]);
        frame_end();
        chk("multi_start_cnt", start_cnt, 2);
        chk("multi_valid_cnt", valid_cnt, 5);
        chk("multi_b0", 32'(rx_mem[1]), 32'h01);
        chk("multi_b1", 32'(rx_mem[2]), 32'h80);
        chk("multi_b2", 32'(rx_mem[3]), 32'hFF);
        chk("multi_b3", 32'(rx_mem[4]), 32'h00);
        chk("multi_miso0", 32'(mcap_arr[0]), 32'h96);
        chk("multi_miso1", 32'(mcap_arr[1]), 32'h96);
        chk("multi_miso2", 32'(mcap_arr[2]), 32'h96);
        chk("multi_miso3", 32'(mcap_arr[3]), 32'h96);

        // Partial byte aborted by ss_n, then a clean 0x5A frame.
        ss_n = 1'b0;
        xfer(8'hFF, 5, mcap);
        frame_end();
        chk("partial_valid_cnt", valid_cnt, 5);
        chk("partial_data_kept", 32'(data), 32'h00);
        ss_n = 1'b0;
        xfer(8'h5A, 8, mcap);
        frame_end();
        chk("after_partial_valid_cnt", valid_cnt, 6);
        chk("after_partial_data", 32'(rx_mem[5]), 32'h5A);
        chk("after_partial_start_cnt", start_cnt, 4);

        // Reset mid-byte with ss_n held low: later sclk edges must be ignored.
        ss_n = 1'b0;
        xfer(8'h77, 3, mcap);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_data", 32'(data), 32'h0);
        xfer(8'hAA, 8, mcap);
        repeat (10) @(negedge clk);
        chk("rst_valid_cnt", valid_cnt, 6);
        chk("rst_start_cnt", start_cnt, 5);
        chk("rst_miso", 32'(miso), 32'h0);
        ss_n = 1'b1;
        repeat (10) @(negedge clk);
        ss_n = 1'b0;
        xfer(8'h77, 8, mcap);
        frame_end();
        chk("post_rst_valid_cnt", valid_cnt, 7);
        chk("post_rst_data", 32'(rx_mem[6]), 32'h77);
        chk("post_rst_start_cnt", start_cnt, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
